// File: rtl/audio_clock_gen_pkg.sv
// audio_clock_gen_pkg: shared constants and helpers for the audio clock generator.
// Holds the default divider settings for 32 kHz audio from an 18.432 MHz system
// clock, plus a helper that sizes the divisor channel-select bus.
package audio_clock_gen_pkg;

  // 18.432 MHz / 9 = 2.048 MHz BCLK; 64 BCLKs per frame gives 32 kHz.
  localparam int DEF_BCLK_DIV         = 9;
  localparam int DEF_BITS_PER_CHANNEL = 32;

  // Width of a select bus for n channels; a single channel still gets one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_clock_gen_div_channel.sv
// audio_clock_gen_div_channel: one divider channel (counter, square level, edge/wrap strobes).
// Ports: clock, reset (sync, active-high), enable (hold when 0), wr/data (shadow divisor write),
//        level, rise_stb, fall_stb, wrap_stb (registered), fall_nxt (fall happening at this edge).
module audio_clock_gen_div_channel
  import audio_clock_gen_pkg::*;
#(
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(40),
  parameter bit               RELOAD   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr,
  input  logic [DIV_W-1:0] data,
  output logic             level,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             wrap_stb,
  output logic             fall_nxt
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             wrap;
  logic             wr_ok;
  logic             lvl_nxt;

  always_comb begin
    wr_ok   = RELOAD && wr && (data != '0);
    wrap    = (cnt == div - DIV_W'(1));
    // The active divisor only changes on a wrap, so a running period is never cut short.
    // A write landing on the wrap cycle bypasses the shadow and governs the next period.
    div_nxt = wrap ? (wr_ok ? data : shadow) : div;
    cnt_nxt = wrap ? '0 : cnt + DIV_W'(1);
    // Level is the registered compare of the upcoming count: low for the first floor(D/2)
    // counts of each period, high for the rest (odd D stays high one cycle longer).
    lvl_nxt  = (cnt_nxt >= (div_nxt >> 1));
    fall_nxt = level & ~lvl_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= DIV_INIT;
    end else if (wr_ok) begin
      shadow <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      div      <= DIV_INIT;
      level    <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      wrap_stb <= 1'b0;
    end else if (enable) begin
      cnt      <= cnt_nxt;
      div      <= div_nxt;
      level    <= lvl_nxt;
      rise_stb <= lvl_nxt & ~level;
      fall_stb <= fall_nxt;
      wrap_stb <= wrap;
    end
  end

endmodule

// File: rtl/audio_clock_gen.sv
// audio_clock_gen: audio serial clocks (bclk, lrclk, sample strobe) plus NUM_TICKS tick channels,
// all as enables/registered levels in the system clock domain. Ports: clock, reset (sync,
// active-high), enable, bclk/bclk_rise_stb/bclk_fall_stb, lrclk, sample_stb, tick_stb, tick_level.
// Optional macro CLKGEN_RUNTIME_DIV_EN adds div_wr/div_sel/div_data for glitch-free divisor updates.
module audio_clock_gen
  import audio_clock_gen_pkg::*;
#(
  parameter int                                BCLK_DIV         = DEF_BCLK_DIV,
  parameter int                                BITS_PER_CHANNEL = DEF_BITS_PER_CHANNEL,
  parameter int                                NUM_TICKS        = 2,
  parameter int                                TICK_DIV_W       = 16,
  parameter logic [NUM_TICKS*TICK_DIV_W-1:0]   TICK_DIV_INIT    = {16'd1024, 16'd40}
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  output logic                            bclk,
  output logic                            bclk_rise_stb,
  output logic                            bclk_fall_stb,
  output logic                            lrclk,
  output logic                            sample_stb,
  output logic [NUM_TICKS-1:0]            tick_stb,
  output logic [NUM_TICKS-1:0]            tick_level
`ifdef CLKGEN_RUNTIME_DIV_EN
  ,
  input  logic                            div_wr,
  input  logic [sel_width(NUM_TICKS)-1:0] div_sel,
  input  logic [TICK_DIV_W-1:0]           div_data
`endif
);

  localparam int SEL_W      = sel_width(NUM_TICKS);
  localparam int FRAME_BITS = 2 * BITS_PER_CHANNEL;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int BCLK_W     = $clog2(BCLK_DIV) + 1;
`ifdef CLKGEN_RUNTIME_DIV_EN
  localparam bit RELOAD_EN  = 1'b1;
`else
  localparam bit RELOAD_EN  = 1'b0;
`endif

  logic                 bclk_level;
  logic                 bclk_rise_r;
  logic                 bclk_fall_r;
  logic                 bclk_fall_nxt;
  logic                 bclk_wrap_unused;
  logic [NUM_TICKS-1:0] tick_level_r;
  logic [NUM_TICKS-1:0] tick_wrap_r;
  logic [NUM_TICKS-1:0] tick_rise_unused;
  logic [NUM_TICKS-1:0] tick_fall_unused;
  logic [NUM_TICKS-1:0] tick_fall_nxt_unused;

  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_nxt;
  logic                 started;
  logic                 lrclk_r;
  logic                 sample_r;

  audio_clock_gen_div_channel #(
    .DIV_W    (BCLK_W),
    .DIV_INIT (BCLK_W'(BCLK_DIV)),
    .RELOAD   (1'b0)
  ) u_bclk (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .wr       (1'b0),
    .data     ('0),
    .level    (bclk_level),
    .rise_stb (bclk_rise_r),
    .fall_stb (bclk_fall_r),
    .wrap_stb (bclk_wrap_unused),
    .fall_nxt (bclk_fall_nxt)
  );

  for (genvar i = 0; i < NUM_TICKS; i++) begin : g_tick
    logic                  ch_wr;
    logic [TICK_DIV_W-1:0] ch_data;
`ifdef CLKGEN_RUNTIME_DIV_EN
    // Out-of-range selects match no channel and are dropped.
    assign ch_wr   = div_wr && (div_sel == SEL_W'(i));
    assign ch_data = div_data;
`else
    assign ch_wr   = 1'b0;
    assign ch_data = '0;
`endif
    audio_clock_gen_div_channel #(
      .DIV_W    (TICK_DIV_W),
      .DIV_INIT (TICK_DIV_INIT[i*TICK_DIV_W +: TICK_DIV_W]),
      .RELOAD   (RELOAD_EN)
    ) u_div (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .wr       (ch_wr),
      .data     (ch_data),
      .level    (tick_level_r[i]),
      .rise_stb (tick_rise_unused[i]),
      .fall_stb (tick_fall_unused[i]),
      .wrap_stb (tick_wrap_r[i]),
      .fall_nxt (tick_fall_nxt_unused[i])
    );
  end

  always_comb begin
    bit_nxt = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
  end

  // Frame state moves on the same edge that raises bclk_fall_stb, so lrclk and
  // sample_stb line up with the fall strobe. The first fall after reset only marks
  // the start of bit 0; counting begins on the next one, so the first sample_stb
  // closes a complete frame rather than firing at reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt  <= '0;
      started  <= 1'b0;
      lrclk_r  <= 1'b0;
      sample_r <= 1'b0;
    end else if (enable) begin
      sample_r <= 1'b0;
      if (bclk_fall_nxt) begin
        if (!started) begin
          started <= 1'b1;
        end else begin
          bit_cnt  <= bit_nxt;
          lrclk_r  <= (bit_nxt >= BIT_W'(BITS_PER_CHANNEL));
          sample_r <= (bit_nxt == '0);
        end
      end
    end
  end

  // Strobe registers hold while disabled and are masked here, so a pending strobe
  // reappears when enable returns instead of being lost or duplicated.
  assign bclk          = bclk_level;
  assign bclk_rise_stb = bclk_rise_r & enable;
  assign bclk_fall_stb = bclk_fall_r & enable;
  assign lrclk         = lrclk_r;
  assign sample_stb    = sample_r & enable;
  assign tick_stb      = tick_wrap_r & {NUM_TICKS{enable}};
  assign tick_level    = tick_level_r;

endmodule
